// File: rtl/bf_nn_pkg.sv
// Shared types and helpers for the bias-free neural predictor training path.
package bf_nn_pkg;

    localparam int NW      = 48;
    localparam int WBITS   = 3;
    localparam int IBITS   = 16;
    localparam int SUMBITS = 9;

    typedef logic signed [WBITS-1:0] weight_t;

    localparam weight_t WMAX = 3'sd3;
    localparam weight_t WMIN = 3'sb100;

    // Widened bounds so the clamp compares in the 4-bit step domain.
    localparam logic signed [WBITS:0] WMAX_W = 4'sd3;
    localparam logic signed [WBITS:0] WMIN_W = -4'sd4;

    // One buffered prediction, index block in the MSBs.
    typedef struct packed {
        logic [NW-1:0][IBITS-1:0]  index;
        logic [NW-1:0][WBITS-1:0]  weights;
        logic [NW-1:0]             hist;
        logic signed [SUMBITS-1:0] sum;
        logic                      taken;
    } pred_entry_t;

    localparam int ENTRY_W = $bits(pred_entry_t);

    // Step a weight by +/-1 in one extra bit of headroom, then clamp back.
    function automatic weight_t sat_step(weight_t w, logic up);
        logic signed [WBITS:0] t;
        t = {w[WBITS-1], w};
        if (up) t = t + 4'sd1;
        else    t = t - 4'sd1;
        if (t > WMAX_W) return WMAX;
        if (t < WMIN_W) return WMIN;
        return t[WBITS-1:0];
    endfunction

endpackage

// File: rtl/bf_train_fifo.sv
// In-order buffer of predictions awaiting resolution. Head is read
// combinationally; pointers carry a wrap bit for full/empty detection.
module bf_train_fifo
    import bf_nn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full buffer is dropped even if the head pops this cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers; flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless outside the rd..wr window.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bf_perceptron_trainer.sv
// Perceptron training side: buffers predictions, applies the update rule
// on resolution and emits one registered write to the weight table.
module bf_perceptron_trainer
    import bf_nn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int THETA = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pred_valid,
    output logic         pred_ready,
    input  logic [767:0] pred_index,
    input  logic [143:0] pred_weights,
    input  logic [47:0]  pred_hist,
    input  logic [8:0]   pred_sum,
    input  logic         pred_taken,
    input  logic         resolve_valid,
    input  logic         resolve_taken,
    input  logic         flush,
    output logic         upd_en,
    output logic [767:0] upd_index,
    output logic [143:0] upd_weights,
    output logic [15:0]  train_cnt,
    output logic [15:0]  mispred_cnt,
    output logic         underflow_err
);

    localparam logic signed [SUMBITS:0] THETA_S = $signed(10'(THETA));

    pred_entry_t              push_ent, head;
    logic [ENTRY_W-1:0]       head_raw;
    logic                     full, empty, pop, mis, train;
    logic signed [SUMBITS:0]  sum_ext, sum_abs;
    logic [NW-1:0][WBITS-1:0] new_w;

    logic                     upd_en_q, upd_en_d;
    logic [767:0]             upd_index_q, upd_index_d;
    logic [143:0]             upd_weights_q, upd_weights_d;
    logic [15:0]              train_cnt_q, train_cnt_d;
    logic [15:0]              mispred_cnt_q, mispred_cnt_d;
    logic                     underflow_q, underflow_d;

    assign push_ent = {pred_index, pred_weights, pred_hist, pred_sum, pred_taken};

    bf_train_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pred_valid),
        .wdata_i (push_ent),
        .pop_i   (resolve_valid),
        .flush_i (flush),
        .rdata_o (head_raw),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head       = pred_entry_t'(head_raw);
    assign pred_ready = !full;
    assign pop        = resolve_valid && !empty;

    // |sum| in one extra bit so -256 maps to +256 rather than wrapping.
    assign sum_ext = head.sum;
    assign sum_abs = (sum_ext < 0) ? -sum_ext : sum_ext;
    assign mis     = (head.taken != resolve_taken);
    assign train   = mis || (sum_abs <= THETA_S);

    for (genvar i = 0; i < NW; i++) begin : g_lane
        assign new_w[i] = sat_step(weight_t'(head.weights[i]), head.hist[i] == resolve_taken);
    end

    // Next state of the write port, counters and underflow flag.
    always_comb begin
        upd_en_d      = pop && train;
        upd_index_d   = upd_index_q;
        upd_weights_d = upd_weights_q;
        train_cnt_d   = train_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        underflow_d   = underflow_q || (resolve_valid && empty);
        if (pop && train) begin
            upd_index_d   = head.index;
            upd_weights_d = new_w;
            if (train_cnt_q != 16'hFFFF) train_cnt_d = train_cnt_q + 16'd1;
        end
        if (pop && mis && mispred_cnt_q != 16'hFFFF) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    // Output and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_en_q      <= 1'b0;
            upd_index_q   <= '0;
            upd_weights_q <= '0;
            train_cnt_q   <= '0;
            mispred_cnt_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            upd_en_q      <= upd_en_d;
            upd_index_q   <= upd_index_d;
            upd_weights_q <= upd_weights_d;
            train_cnt_q   <= train_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign upd_en        = upd_en_q;
    assign upd_index     = upd_index_q;
    assign upd_weights   = upd_weights_q;
    assign train_cnt     = train_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_bf_perceptron_trainer.sv
// Bench for bf_perceptron_trainer: queue-based reference model, a vector
// table, directed corner sequences and a randomized run.
module tb_bf_perceptron_trainer;

    localparam int DEPTH = 4;
    localparam int THETA = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pred_valid = 1'b0;
    logic         pred_ready;
    logic [767:0] pred_index = '0;
    logic [143:0] pred_weights = '0;
    logic [47:0]  pred_hist = '0;
    logic [8:0]   pred_sum = '0;
    logic         pred_taken = 1'b0;
    logic         resolve_valid = 1'b0;
    logic         resolve_taken = 1'b0;
    logic         flush = 1'b0;
    logic         upd_en;
    logic [767:0] upd_index;
    logic [143:0] upd_weights;
    logic [15:0]  train_cnt;
    logic [15:0]  mispred_cnt;
    logic         underflow_err;

    bf_perceptron_trainer #(.DEPTH(DEPTH), .THETA(THETA)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_index(pred_index), .pred_weights(pred_weights),
        .pred_hist(pred_hist), .pred_sum(pred_sum), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .flush(flush),
        .upd_en(upd_en), .upd_index(upd_index), .upd_weights(upd_weights),
        .train_cnt(train_cnt), .mispred_cnt(mispred_cnt),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [767:0] idx;
        logic [143:0] w;
        logic [47:0]  h;
        logic [8:0]   s;
        logic         t;
    } ent_t;

    ent_t         q[$];
    logic         exp_en = 1'b0;
    logic [767:0] exp_idx = '0;
    logic [143:0] exp_w = '0;
    int           exp_tc = 0;
    int           exp_mc = 0;
    logic         exp_uf = 1'b0;

    typedef struct {
        logic [2:0]  w;
        logic [47:0] h;
        logic [8:0]  s;
        logic        pt;
        logic        rt;
        logic        exp_en;
        logic [2:0]  exp_w;
    } vec_t;

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, expv);
        end
    endtask

    // Perceptron rule with plain integer arithmetic and clamping.
    function automatic logic [143:0] ref_w(input logic [143:0] w, input logic [47:0] h, input logic rt);
        logic [143:0] r;
        for (int i = 0; i < 48; i++) begin
            int v;
            v = $signed(w[3*i +: 3]);
            v = v + ((h[i] == rt) ? 1 : -1);
            if (v > 3)  v = 3;
            if (v < -4) v = -4;
            r[3*i +: 3] = v[2:0];
        end
        return r;
    endfunction

    function automatic logic [767:0] rand_idx();
        logic [767:0] r;
        for (int j = 0; j < 48; j++) r[16*j +: 16] = 16'($urandom);
        return r;
    endfunction

    function automatic logic [143:0] rand_w();
        logic [143:0] r;
        for (int j = 0; j < 48; j++) r[3*j +: 3] = 3'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_en = 0; exp_idx = '0; exp_w = '0;
        exp_tc = 0; exp_mc = 0; exp_uf = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare every output just after the edge.
    task automatic cycle();
        bit   full;
        ent_t e;
        int   s, a;
        bit   mis, tr;
        full = (q.size() == DEPTH);
        chk("pred_ready_pre", 768'(pred_ready), 768'(!full));
        exp_en = 0;
        if (resolve_valid) begin
            if (q.size() == 0) exp_uf = 1;
            else begin
                e   = q.pop_front();
                mis = (e.t != resolve_taken);
                s   = $signed(e.s);
                a   = (s < 0) ? -s : s;
                tr  = mis || (a <= THETA);
                if (mis && exp_mc < 65535) exp_mc++;
                if (tr) begin
                    exp_en  = 1;
                    exp_idx = e.idx;
                    exp_w   = ref_w(e.w, e.h, resolve_taken);
                    if (exp_tc < 65535) exp_tc++;
                end
            end
        end
        if (pred_valid && !full && !flush)
            q.push_back('{pred_index, pred_weights, pred_hist, pred_sum, pred_taken});
        if (flush) q.delete();
        @(posedge clk);
        #1;
        chk("upd_en", 768'(upd_en), 768'(exp_en));
        chk("upd_index", upd_index, exp_idx);
        chk("upd_weights", 768'(upd_weights), 768'(exp_w));
        chk("train_cnt", 768'(train_cnt), 768'(16'(exp_tc)));
        chk("mispred_cnt", 768'(mispred_cnt), 768'(16'(exp_mc)));
        chk("underflow_err", 768'(underflow_err), 768'(exp_uf));
        chk("pred_ready", 768'(pred_ready), 768'(q.size() != DEPTH));
    endtask

    task automatic set_pred(input logic [767:0] idx, input logic [143:0] w,
                            input logic [47:0] h, input logic [8:0] s, input logic t);
        pred_valid = 1; pred_index = idx; pred_weights = w;
        pred_hist = h; pred_sum = s; pred_taken = t;
    endtask

    vec_t         tbl[10];
    logic [767:0] ids[5];

    initial begin
        tbl[0] = '{3'b000, {48{1'b1}}, 9'd5,     1'b1, 1'b1, 1'b1, 3'b001};
        tbl[1] = '{3'b011, {48{1'b1}}, 9'd100,   1'b0, 1'b1, 1'b1, 3'b011};
        tbl[2] = '{3'b011, {48{1'b1}}, 9'd100,   1'b1, 1'b1, 1'b0, 3'b000};
        tbl[3] = '{3'b100, 48'd0,      9'd0,     1'b1, 1'b1, 1'b1, 3'b100};
        tbl[4] = '{3'b010, 48'd0,      9'h1EC,   1'b0, 1'b0, 1'b1, 3'b011};
        tbl[5] = '{3'b001, 48'd0,      9'h1EB,   1'b0, 1'b0, 1'b0, 3'b000};
        tbl[6] = '{3'b001, {48{1'b1}}, 9'd21,    1'b1, 1'b1, 1'b0, 3'b000};
        tbl[7] = '{3'b001, {48{1'b1}}, 9'd20,    1'b1, 1'b1, 1'b1, 3'b010};
        tbl[8] = '{3'b000, 48'd0,      9'h100,   1'b0, 1'b0, 1'b0, 3'b000};
        tbl[9] = '{3'b111, 48'd0,      9'd255,   1'b0, 1'b1, 1'b1, 3'b110};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_upd_en", 768'(upd_en), 768'(1'b0));
        chk("rst_upd_index", upd_index, 768'(0));
        chk("rst_upd_weights", 768'(upd_weights), 768'(0));
        chk("rst_ready", 768'(pred_ready), 768'(1'b1));
        chk("rst_cnts", 768'({train_cnt, mispred_cnt}), 768'(0));
        chk("rst_uf", 768'(underflow_err), 768'(1'b0));
        rst = 0;
        model_reset();

        // Vector table: push one entry, resolve it, check the write.
        for (int k = 0; k < 10; k++) begin
            logic [767:0] id;
            id = rand_idx();
            set_pred(id, {48{tbl[k].w}}, tbl[k].h, tbl[k].s, tbl[k].pt);
            cycle();
            pred_valid = 0; resolve_valid = 1; resolve_taken = tbl[k].rt;
            cycle();
            resolve_valid = 0;
            chk("tbl_en", 768'(upd_en), 768'(tbl[k].exp_en));
            if (tbl[k].exp_en) begin
                chk("tbl_w", 768'(upd_weights), 768'({48{tbl[k].exp_w}}));
                chk("tbl_idx", upd_index, id);
            end
            if (k == 0) chk("tbl_first_cnts", 768'({train_cnt, mispred_cnt}), 768'({16'd1, 16'd0}));
        end

        // Mixed lanes: only lane 5 agrees and climbs off the floor.
        set_pred(rand_idx(), {48{3'b100}}, 48'h20, 9'd0, 1'b1);
        cycle();
        pred_valid = 0; resolve_valid = 1; resolve_taken = 1;
        cycle();
        resolve_valid = 0;
        chk("mix_lane5", 768'(upd_weights[17:15]), 768'(3'b101));
        chk("mix_lane0", 768'(upd_weights[2:0]), 768'(3'b100));

        // Fill to DEPTH, drop a push-while-full that coincides with a pop.
        for (int k = 0; k < 5; k++) ids[k] = rand_idx();
        for (int k = 0; k < 4; k++) begin
            set_pred(ids[k], rand_w(), 48'($urandom), 9'd0, 1'b1);
            cycle();
        end
        chk("full_ready", 768'(pred_ready), 768'(1'b0));
        set_pred(ids[4], rand_w(), 48'($urandom), 9'd0, 1'b1);
        resolve_valid = 1; resolve_taken = 1;
        cycle();
        pred_valid = 0;
        chk("full_pop0", upd_index, ids[0]);
        chk("full_drop_ready", 768'(pred_ready), 768'(1'b1));
        for (int k = 1; k < 4; k++) begin
            cycle();
            chk("full_pop_order", upd_index, ids[k]);
        end
        cycle();
        resolve_valid = 0;
        chk("uf_set", 768'(underflow_err), 768'(1'b1));
        chk("uf_no_write", 768'(upd_en), 768'(1'b0));

        // Flush with a simultaneous resolve.
        for (int k = 0; k < 3; k++) begin
            set_pred(ids[k], rand_w(), 48'($urandom), 9'd3, 1'b0);
            cycle();
        end
        pred_valid = 1; pred_index = ids[4];
        flush = 1; resolve_valid = 1; resolve_taken = 0;
        cycle();
        flush = 0; resolve_valid = 0; pred_valid = 0;
        chk("flush_upd", 768'(upd_en), 768'(1'b1));
        chk("flush_idx", upd_index, ids[0]);
        chk("flush_ready", 768'(pred_ready), 768'(1'b1));
        cycle();

        // Async reset while a write is pending and two entries are buffered.
        for (int k = 0; k < 2; k++) begin
            set_pred(ids[k], rand_w(), 48'($urandom), 9'd0, 1'b1);
            cycle();
        end
        set_pred(ids[2], rand_w(), 48'($urandom), 9'd0, 1'b1);
        resolve_valid = 1; resolve_taken = 1;
        cycle();
        pred_valid = 0; resolve_valid = 0;
        chk("pre_rst_en", 768'(upd_en), 768'(1'b1));
        #1 rst = 1;
        #1;
        chk("arst_en", 768'(upd_en), 768'(1'b0));
        chk("arst_cnts", 768'({train_cnt, mispred_cnt}), 768'(0));
        chk("arst_ready", 768'(pred_ready), 768'(1'b1));
        chk("arst_uf", 768'(underflow_err), 768'(1'b0));
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        resolve_valid = 1; resolve_taken = 1;
        cycle();
        resolve_valid = 0;
        chk("arst_empty", 768'(underflow_err), 768'(1'b1));

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            pred_valid    = ($urandom_range(0, 99) < 55);
            pred_index    = rand_idx();
            pred_weights  = rand_w();
            pred_hist     = {16'($urandom), 32'($urandom)};
            pred_sum      = 9'(int'($urandom_range(0, 100)) - 50);
            pred_taken    = 1'($urandom);
            resolve_valid = ($urandom_range(0, 99) < 45);
            resolve_taken = 1'($urandom);
            flush         = ($urandom_range(0, 99) < 3);
            cycle();
        end
        pred_valid = 0; resolve_valid = 0; flush = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
